bcd_scan_display: RTL and testbench

//   Downstream consumer of the mod-10 BCD digit counters. Snapshots a packed

---
 rtl/bcd_scan_display.sv | 97 +++++++++
 tb/tb_bcd_scan_display.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: snapshot a packed BCD vector and scan it onto a common-anode 7-segment display.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_scan_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                load,
    output logic [DIGITS-1:0]   ssd_an,
    output logic [7:0]          ssd_seg,
    output logic [2:0]          digit_idx
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);

    logic [4*DIGITS-1:0] snap_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          idx_q;
    logic                tick;
    logic [3:0]          cur_bcd;
    logic [6:0]          cur_seg;
    logic                blank;

    assign tick = cnt_q == CNT_LAST;

    // Snapshot, refresh divider and scan index; the snapshot only moves on load so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
        end else begin
            if (load)
                snap_q <= bcd_in;
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (tick)
                idx_q <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Pick the snapshot digit addressed by the scan index
    always_comb begin
        cur_bcd = '0;
        for (int k = 0; k < DIGITS; k++)
            if (idx_q == 3'(k))
                cur_bcd = snap_q[4*k +: 4];
    end

    // BCD to active-low {a..g}; codes above 9 show a dash
    always_comb begin
        case (cur_bcd)
            4'd0:    cur_seg = 7'b0000001;
            4'd1:    cur_seg = 7'b1001111;
            4'd2:    cur_seg = 7'b0010010;
            4'd3:    cur_seg = 7'b0000110;
            4'd4:    cur_seg = 7'b1001100;
            4'd5:    cur_seg = 7'b0100100;
            4'd6:    cur_seg = 7'b0100000;
            4'd7:    cur_seg = 7'b0001111;
            4'd8:    cur_seg = 7'b0000000;
            4'd9:    cur_seg = 7'b0000100;
            default: cur_seg = 7'b1111110;
        endcase
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // A digit above 0 is dark when it and every more-significant digit are zero
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank    = 1'b0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run && (snap_q[4*k +: 4] == 4'd0);
            if (idx_q == 3'(k))
                blank = zero_run;
        end
    end
`else
    assign blank = 1'b0;
`endif

    // Registered outputs from the current index and snapshot, no bypass of same-edge updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssd_an    <= '1;
            ssd_seg   <= 8'hFF;
            digit_idx <= '0;
        end else begin
            ssd_an    <= blank ? '1 : ~(DIGITS'(1) << idx_q);
            ssd_seg   <= blank ? 8'hFF : {cur_seg, 1'b1};
            digit_idx <= idx_q;
        end
    end
endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: directed bench for bcd_scan_display with DIGITS=4, REFRESH_DIV=4.
// Define SSD_LEADING_ZERO_BLANK_EN on both RTL and bench to exercise zero blanking.
module tb_bcd_scan_display;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        load = 1'b0;
    logic [3:0]  ssd_an;
    logic [7:0]  ssd_seg;
    logic [2:0]  digit_idx;

    int checks = 0;
    int errors = 0;
    logic [7:0] seg_tab [16];

    bcd_scan_display #(.DIGITS(4), .REFRESH_DIV(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
        .ssd_an(ssd_an), .ssd_seg(ssd_seg), .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    // Hold reset for two clocks, release on a falling edge; the next falling edge follows post-reset clock 1
    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        load = 1'b0;
        bcd_in = 16'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ssd_an !== 4'hF) begin errors++; $display("FAIL reset_an got %h exp %h", ssd_an, 4'hF); end
        checks++;
        if (ssd_seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h exp %h", ssd_seg, 8'hFF); end
        checks++;
        if (digit_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", digit_idx); end
    endtask

    task automatic test_scan();
        reset_dut();
        for (int k = 1; k <= 17; k++) begin
            int slot;
            logic [3:0] e_an;
            @(negedge clk);
            slot = ((k - 1) / 4) % 4;
            e_an = ~(4'b0001 << slot);
            checks++;
            if (ssd_an !== e_an) begin errors++; $display("FAIL scan_an k=%0d got %h exp %h", k, ssd_an, e_an); end
            checks++;
            if (ssd_seg !== 8'h03) begin errors++; $display("FAIL scan_seg k=%0d got %h exp 03", k, ssd_seg); end
            checks++;
            if (digit_idx !== 3'(slot)) begin errors++; $display("FAIL scan_idx k=%0d got %0d exp %0d", k, digit_idx, slot); end
        end
    endtask

    task automatic test_load();
        logic [15:0] v;
        v = 16'h1234;
        reset_dut();
        bcd_in = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (ssd_seg !== 8'h03) begin errors++; $display("FAIL load_latency got %h exp 03", ssd_seg); end
        for (int k = 2; k <= 16; k++) begin
            int slot;
            logic [7:0] e_seg;
            @(negedge clk);
            slot = (k - 1) / 4;
            e_seg = seg_tab[v[slot*4 +: 4]];
            checks++;
            if (ssd_seg !== e_seg) begin errors++; $display("FAIL load_seg k=%0d got %h exp %h", k, ssd_seg, e_seg); end
            checks++;
            if (ssd_an !== ~(4'b0001 << slot)) begin errors++; $display("FAIL load_an k=%0d got %h exp %h", k, ssd_an, ~(4'b0001 << slot)); end
        end
    endtask

    task automatic test_hold();
        logic [15:0] v;
        v = 16'h00A7;
        reset_dut();
        bcd_in = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        bcd_in = 16'h9999;
        for (int k = 2; k <= 16; k++) begin
            int slot;
            logic [7:0] e_seg;
            @(negedge clk);
            slot = (k - 1) / 4;
            e_seg = seg_tab[v[slot*4 +: 4]];
            checks++;
            if (ssd_seg !== e_seg) begin errors++; $display("FAIL hold_seg k=%0d got %h exp %h", k, ssd_seg, e_seg); end
        end
    endtask

    task automatic test_load_on_tick();
        reset_dut();
        bcd_in = 16'h1234;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) begin
                bcd_in = 16'h5678;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            checks++;
            if ($countones(~ssd_an) != 1) begin errors++; $display("FAIL tick_onehot k=%0d got %h exp one low", k, ssd_an); end
            if (k == 4) begin
                checks++;
                if (ssd_seg !== 8'h99 || ssd_an !== 4'hE) begin errors++; $display("FAIL tick_old got an=%h seg=%h exp an=E seg=99", ssd_an, ssd_seg); end
            end
            if (k == 5) begin
                checks++;
                if (ssd_seg !== 8'h1F || ssd_an !== 4'hD || digit_idx !== 3'd1) begin
                    errors++; $display("FAIL tick_new got an=%h seg=%h idx=%0d exp an=D seg=1F idx=1", ssd_an, ssd_seg, digit_idx);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        bcd_in = 16'h1234;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (digit_idx !== 3'd2) begin errors++; $display("FAIL mid_idx got %0d exp 2", digit_idx); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ssd_an !== 4'hF) begin errors++; $display("FAIL async_an got %h exp F", ssd_an); end
        checks++;
        if (ssd_seg !== 8'hFF) begin errors++; $display("FAIL async_seg got %h exp FF", ssd_seg); end
        checks++;
        if (digit_idx !== 3'd0) begin errors++; $display("FAIL async_idx got %0d exp 0", digit_idx); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            int slot;
            @(negedge clk);
            slot = (k - 1) / 4;
            checks++;
            if (ssd_an !== ~(4'b0001 << slot) || ssd_seg !== 8'h03) begin
                errors++; $display("FAIL restart k=%0d got an=%h seg=%h exp an=%h seg=03", k, ssd_an, ssd_seg, ~(4'b0001 << slot));
            end
        end
    endtask

`ifdef SSD_LEADING_ZERO_BLANK_EN
    task automatic test_blank();
        logic [3:0] e_an [4];
        logic [7:0] e_seg [4];
        e_an  = '{4'hE, 4'hD, 4'hF, 4'hF};
        e_seg = '{8'h03, 8'h49, 8'hFF, 8'hFF};
        reset_dut();
        bcd_in = 16'h0050;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            int slot;
            @(negedge clk);
            slot = (k - 1) / 4;
            checks++;
            if (ssd_an !== e_an[slot] || ssd_seg !== e_seg[slot]) begin
                errors++; $display("FAIL blank50 k=%0d got an=%h seg=%h exp an=%h seg=%h", k, ssd_an, ssd_seg, e_an[slot], e_seg[slot]);
            end
        end
        bcd_in = 16'h0000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        e_an  = '{4'hE, 4'hF, 4'hF, 4'hF};
        e_seg = '{8'h03, 8'hFF, 8'hFF, 8'hFF};
        repeat (4) @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (ssd_an !== e_an[digit_idx[1:0]] || ssd_seg !== e_seg[digit_idx[1:0]]) begin
                errors++; $display("FAIL blank00 k=%0d got an=%h seg=%h", k, ssd_an, ssd_seg);
            end
        end
    endtask
`endif

    initial begin
        seg_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                    8'h01, 8'h09, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD};
        test_reset();
        test_scan();
        test_load();
        test_hold();
        test_load_on_tick();
        test_async_reset();
`ifdef SSD_LEADING_ZERO_BLANK_EN
        test_blank();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
